// File: rtl/regression_pkg.sv
// Shared types for the regression solver cluster.
// State encoding, default word width, index-width helper.
package regression_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regression_scheduler_rr_arbiter.sv
// Round-robin arbiter: first req after last_grant wins.
// Ports: req, last_grant in; one-hot grant, grant_idx out.
module rr_arbiter
  import regression_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   last_grant,
  output logic [N-1:0]          grant,
  output logic [idx_w(N)-1:0]   grant_idx
);

  localparam int IW = idx_w(N);

  logic [IW:0] pos;

  // Walk from farthest to nearest so the closest
  // requester after last_grant overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    pos       = '0;
    for (int k = N; k >= 1; k--) begin
      pos = {1'b0, last_grant} + (IW+1)'(k);
      if (pos >= (IW+1)'(N))
        pos = pos - (IW+1)'(N);
      if (req[pos[IW-1:0]]) begin
        grant              = '0;
        grant[pos[IW-1:0]] = 1'b1;
        grant_idx          = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regression_scheduler.sv
// Shares one 3x3 regression solver among N_REQ requesters.
// Ports: req_* handshake in, resp_* strobe out, slv_* solver side.
module regression_scheduler
  import regression_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*9*WIDTH-1:0] req_A,
  input  logic [N_REQ*3*WIDTH-1:0] req_B,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [3*WIDTH-1:0]       resp_beta,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     slv_start,
  output logic [9*WIDTH-1:0]       slv_A,
  output logic [3*WIDTH-1:0]       slv_B,
  input  logic                     slv_done,
  input  logic [3*WIDTH-1:0]       slv_beta
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int AW = 9 * WIDTH;
  localparam int BW = 3 * WIDTH;

  sched_state_t   state;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  act_id;
  logic [IW-1:0]  gidx;
  logic [N_REQ-1:0] grant;
  logic [CW-1:0]  wait_cnt;
  logic           hs;
  logic           to_hit;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (gidx)
  );

  // grant is a subset of req_valid, so any ready
  // bit marks a completed handshake.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign hs        = |req_ready;
  assign busy      = (state != IDLE);
  assign slv_start = (state == ISSUE);
  assign resp_valid = (state == RESP)
    ? ({{(N_REQ-1){1'b0}}, 1'b1} << act_id)
    : '0;
  assign to_hit = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      act_id     <= '0;
      wait_cnt   <= '0;
      slv_A      <= '0;
      slv_B      <= '0;
      resp_beta  <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            slv_A      <= req_A[int'(gidx)*AW +: AW];
            slv_B      <= req_B[int'(gidx)*BW +: BW];
            act_id     <= gidx;
            last_grant <= gidx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // done beats timeout on the same cycle
          if (slv_done) begin
            resp_beta <= slv_beta;
            resp_err  <= 1'b0;
            state     <= RESP;
          end else if (to_hit) begin
            resp_beta <= '0;
            resp_err  <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regression_scheduler.sv
// Scoreboard bench for regression_scheduler.
// Directed requests, solver model, decoupled monitor.
module tb_regression_scheduler;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int AW = 9 * W;
  localparam int BW = 3 * W;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_A;
  logic [N*BW-1:0] req_B;
  logic [N-1:0]    resp_valid;
  logic [BW-1:0]   resp_beta;
  logic            resp_err;
  logic            busy;
  logic            slv_start;
  logic [AW-1:0]   slv_A;
  logic [BW-1:0]   slv_B;
  logic            slv_done;
  logic [BW-1:0]   slv_beta;

  typedef struct {
    int            id;
    logic [BW-1:0] beta;
    logic          err;
    int            cyc;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
  } exp_t;

  exp_t q[$];
  int vecs = 0;
  int miss = 0;
  int cyc  = 0;
  int sol_delay = 1;
  bit spur = 1'b0;

  regression_scheduler #(
    .WIDTH(W), .N_REQ(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B),
    .resp_valid(resp_valid), .resp_beta(resp_beta),
    .resp_err(resp_err), .busy(busy),
    .slv_start(slv_start), .slv_A(slv_A), .slv_B(slv_B),
    .slv_done(slv_done), .slv_beta(slv_beta)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm,
                     input logic [AW-1:0] act,
                     input logic [AW-1:0] req);
    vecs++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               nm, act, req, cyc);
    end
  endtask

  function automatic logic [AW-1:0] lane_a(input int i);
    return req_A[i*AW +: AW];
  endfunction

  function automatic logic [BW-1:0] lane_b(input int i);
    return req_B[i*BW +: BW];
  endfunction

  // Solver model: replies sol_delay cycles after start
  // with the B it was handed (identity A solve).
  initial begin
    int pend;
    pend = 0;
    slv_done = 1'b0;
    slv_beta = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
        slv_done = 1'b0;
      end else begin
        slv_done = spur;
        if (pend > 0) begin
          pend--;
          if (pend == 0) slv_done = 1'b1;
        end
        if (slv_start && sol_delay > 0) begin
          pend = sol_delay;
          slv_beta = slv_B;
        end
      end
    end
  end

  // Monitor: pops one expectation per resp_valid.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy) chk("ready_busy", AW'(req_ready), '0);
    if (resp_valid != '0) begin
      vecs++;
      if (q.size() == 0) begin
        miss++;
        $display("FAIL unexpected_resp: got %0h want none",
                 resp_valid);
      end else begin
        e = q.pop_front();
        chk("resp_id", AW'(resp_valid),
            AW'(N'(1) << e.id));
        chk("resp_beta", AW'(resp_beta), AW'(e.beta));
        chk("resp_err", AW'(resp_err), AW'(e.err));
        chk("resp_cyc", AW'(cyc), AW'(e.cyc));
        chk("slv_A_stable", slv_A, e.a);
        chk("slv_B_stable", AW'(slv_B), AW'(e.b));
      end
    end
  end

  function automatic exp_t mk_exp(input int id,
                                  input int d,
                                  input int c);
    exp_t e;
    e.id   = id;
    e.a    = lane_a(id);
    e.b    = lane_b(id);
    e.err  = (d == 0);
    e.beta = (d == 0) ? '0 : lane_b(id);
    e.cyc  = (d == 0) ? c + TO + 2 : c + d + 2;
    return e;
  endfunction

  task automatic do_req(input logic [N-1:0] mask,
                        input int id,
                        input int d,
                        input bit exp_resp);
    @(negedge clk);
    sol_delay = d;
    req_valid = mask;
    #1;
    chk("grant", AW'(req_ready), AW'(N'(1) << id));
    if (exp_resp) q.push_back(mk_exp(id, d, cyc));
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("start_pulse", AW'(slv_start), AW'(1));
    chk("busy_issue", AW'(busy), AW'(1));
    @(negedge clk);
    chk("start_drop", AW'(slv_start), '0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (q.size() != 0) begin
      miss++;
      $display("FAIL drain: %0d pending want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int got;
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 9; k++)
        req_A[(i*9+k)*W +: W] = (i == 0)
          ? ((k % 4 == 0) ? 32'h7fff_ffff : 32'h0)
          : W'(i*100 + k);
      for (int j = 0; j < 3; j++)
        req_B[(i*3+j)*W +: W] = W'(i*10 + j + 1);
    end

    repeat (2) @(negedge clk);
    chk("rst_ready", AW'(req_ready), '0);
    chk("rst_resp", AW'(resp_valid), '0);
    chk("rst_busy", AW'(busy), '0);
    chk("rst_start", AW'(slv_start), '0);
    chk("rst_beta", AW'(resp_beta), '0);
    chk("rst_err", AW'(resp_err), '0);
    chk("rst_slvA", slv_A, '0);
    chk("rst_slvB", AW'(slv_B), '0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // single request, 5-cycle solver
    do_req(4'b0001, 0, 5, 1'b1);
    drain();
    chk("hold_beta", AW'(resp_beta),
        AW'({32'd3, 32'd2, 32'd1}));
    chk("hold_err", AW'(resp_err), '0);

    // contention from fresh priority
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sol_delay = 1;
    @(negedge clk);
    req_valid = '1;
    got = 0;
    for (int t = 0; t < 200 && got < 5; t++) begin
      #1;
      if (req_ready != '0) begin
        chk("rr_order", AW'(req_ready),
            AW'(N'(1) << (got % N)));
        q.push_back(mk_exp(got % N, 1, cyc));
        got++;
      end
      if (got < 5) @(negedge clk);
    end
    chk("rr_count", AW'(got), AW'(5));
    @(posedge clk);
    #1 req_valid = '0;
    drain();

    // timeout, with req inputs changing mid-WAIT
    do_req(4'b0100, 2, 0, 1'b1);
    repeat (3) @(negedge clk);
    req_A = ~req_A;
    req_B = ~req_B;
    drain();
    chk("to_hold_err", AW'(resp_err), AW'(1));
    chk("to_hold_beta", AW'(resp_beta), '0);
    do_req(4'b1000, 3, 1, 1'b1);
    drain();

    // done on the last timeout cycle
    do_req(4'b0001, 0, TO, 1'b1);
    drain();

    // spurious done while idle
    @(posedge clk);
    #1 spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("spur_resp", AW'(resp_valid), '0);
      chk("spur_busy", AW'(busy), '0);
    end

    // reset three cycles into WAIT
    do_req(4'b0010, 1, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", AW'(busy), '0);
    chk("abort_resp", AW'(resp_valid), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (TO + 4) @(negedge clk);
    chk("abort_idle", AW'(busy), '0);
    do_req(4'b0110, 1, 1, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule

// File: doc/regression_scheduler.md
REGRESSION_SCHEDULER -- requirements
Module: regression_scheduler

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 32, fixed-point word width.
- N_REQ, default 4, number of requesters (2..8).
- TIMEOUT, default 1024, maximum solver wait in cycles.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester solve request.
- req_ready  out  N_REQ  one-hot grant/accept.
- req_A  in  N_REQ*9*WIDTH  per-requester 3x3 A, row-major, signed.
- req_B  in  N_REQ*3*WIDTH  per-requester 3x1 B, signed.
- resp_valid  out  N_REQ  one-hot, one-cycle result strobe.
- resp_beta  out  3*WIDTH  shared result bus, beta[0] in LSBs.
- resp_err  out  1  qualifies resp_valid; 1 means timeout.
- busy  out  1  high whenever state is not IDLE.
- slv_start  out  1  one-cycle solver start pulse.
- slv_A  out  9*WIDTH  latched A to solver.
- slv_B  out  3*WIDTH  latched B to solver.
- slv_done  in  1  solver completion strobe.
- slv_beta  in  3*WIDTH  solver solution, valid with slv_done.

REQ-003 The interface SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; there are no other states.

REQ-005 In IDLE with any req_valid high, the block SHALL assert req_ready for exactly one requester in the same cycle (combinational).
- That requester is the first with req_valid set, searching round-robin from last_grant+1 mod N_REQ.

REQ-006 On the handshake edge (req_valid[i] & req_ready[i]) the block SHALL:
- latch req_A[i] and req_B[i] into slv_A and slv_B;
- store i as the active id;
- update last_grant to i;
- enter ISSUE.

REQ-007 req_ready SHALL be all-zero in ISSUE, WAIT and RESP.

REQ-008 In ISSUE, slv_start SHALL be 1 for exactly one cycle; next state is WAIT.

REQ-009 slv_A and slv_B SHALL remain stable from the handshake edge until the exit from RESP.

REQ-010 In WAIT, a wait counter SHALL start at 0 and increment each cycle.
- slv_done=1: capture slv_beta, set err=0, go to RESP.
- Counter reaches TIMEOUT-1 without slv_done: set err=1, beta=0, go to RESP.
- slv_done and the timeout in the same cycle: slv_done wins (err=0).

REQ-011 In RESP, for exactly one cycle, the block SHALL drive:
- resp_valid[id]=1;
- resp_beta and resp_err from the captured values.
Next state is IDLE.

REQ-012 resp_beta and resp_err SHALL hold their last values outside RESP; they are 0 after reset.

REQ-013 The block SHALL ignore slv_done outside WAIT.

REQ-014 Best-case latency, handshake edge to resp_valid, SHALL be 3 cycles for a solver answering 1 cycle after slv_start.

REQ-015 A requester whose req_valid stays high SHALL be re-served no sooner than one full round-robin pass when others are pending; there is no starvation.

REQ-016 A requester dropping req_valid before grant SHALL simply not be granted; requests are not latched pre-grant.

REQ-017 The wait counter SHALL be $clog2(TIMEOUT)+1 bits, saturating; it SHALL never wrap.

Reset
REQ-018 While rst is high, the block SHALL force:
- state=IDLE;
- last_grant=N_REQ-1, so requester 0 has first priority;
- all outputs 0;
- wait counter 0.

REQ-019 Reset asserted mid-operation (ISSUE/WAIT/RESP) SHALL abort with no resp_valid pulse.
- A slv_done arriving after reset release SHALL be ignored (IDLE).

Structure
REQ-020 Shared package regression_pkg SHALL hold the sched_state_t typedef (IDLE, ISSUE, WAIT, RESP) and the WIDTH default constant; solveRegression3x3 also uses this package.

REQ-021 Round-robin selection SHALL be one sub-module, rr_arbiter (N parameter; inputs req and last_grant; outputs one-hot grant and its index); everything else is inline.

REQ-022 The design SHALL contain no combinational path from slv_done to req_ready.

Verification
REQ-023 Single request:
- Stimulus: req_valid=4'b0001 with A=identity (1.0 Q31-scaled), B={1,2,3}; solver model answers 5 cycles after start.
- Required: req_ready[0] in the same cycle, slv_start one cycle later, resp_valid=4'b0001 with resp_beta={1,2,3}, resp_err=0.

REQ-024 Contention:
- Stimulus: req_valid=4'b1111 held continuously.
- Required: grant order 0,1,2,3,0; exactly one resp_valid per grant, matching id.

REQ-025 Timeout:
- Stimulus: TIMEOUT=16, solver never answers.
- Required: resp_valid after 16 WAIT cycles with resp_err=1 and resp_beta=0; next request still served.

REQ-026 Simultaneous events:
- Stimulus: slv_done on the final timeout cycle.
- Required: resp_err=0 and the solver beta captured.
- Stimulus: a spurious slv_done in IDLE.
- Required: no resp_valid.

REQ-027 Reset mid-WAIT:
- Stimulus: rst pulsed 3 cycles into WAIT.
- Required: busy=0 and no resp_valid; the next grant with req_valid=4'b0110 goes to requester 1.

REQ-028 Stability:
- Check: slv_A and slv_B unchanged while req_A changes during WAIT.
- Check: req_ready all-zero whenever busy=1.
